seg7_count_ctrl: RTL



---
 rtl/seg7_ctrl_pkg.sv | 12 +
 rtl/seg7_count_ctrl_if.sv | 26 ++
 rtl/seg7_decoder.sv | 11 +
 rtl/seg7_count_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/seg7_ctrl_pkg.sv
// seg7_ctrl_pkg: shared FSM state type and hex-to-segment table for the 7-segment counter
package seg7_ctrl_pkg;

    typedef enum logic {HOLD = 1'b0, RUN = 1'b1} state_t;

    // Active-high segments, bit0=a .. bit6=g, indexed by hex digit
    localparam logic [15:0][6:0] SEG_TAB = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_count_ctrl_if.sv
// seg7_count_ctrl_if: control inputs and display outputs of the 7-segment counter
interface seg7_count_ctrl_if #(parameter int PRESCALE_W = 16);

    logic                  ena;
    logic                  run_i;
    logic                  step_i;
    logic                  load_i;
    logic [3:0]            load_val;
    logic [3:0]            term_val;
    logic [PRESCALE_W-1:0] prescale;
    logic [3:0]            digit_o;
    logic [6:0]            seg_o;
    logic                  dp_o;
    logic                  wrap_o;

    modport master (
        output ena, run_i, step_i, load_i, load_val, term_val, prescale,
        input  digit_o, seg_o, dp_o, wrap_o
    );

    modport slave (
        input  ena, run_i, step_i, load_i, load_val, term_val, prescale,
        output digit_o, seg_o, dp_o, wrap_o
    );

endinterface

// File: rtl/seg7_decoder.sv
// seg7_decoder: combinational hex digit to active-high 7-segment pattern
module seg7_decoder
    import seg7_ctrl_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = SEG_TAB[digit];

endmodule

// File: rtl/seg7_count_ctrl.sv
// seg7_count_ctrl: RUN/HOLD hex digit counter with prescaled tick, step button and 7-seg output.
// Optional macro SEG7_CTRL_DEBOUNCE_EN adds a DEB_CYCLES stability filter on the step button.
module seg7_count_ctrl
    import seg7_ctrl_pkg::*;
#(
    parameter int PRESCALE_W = 16,
    parameter int DEB_CYCLES = 4
)(
    input logic clk,
    input logic rst_n,
    seg7_count_ctrl_if.slave bus
);

    state_t                state;
    logic [PRESCALE_W-1:0] pc;
    logic [3:0]            digit;
    logic                  wrap;
    logic                  dp;
    logic                  s1, s2, s3;
    logic                  step_p;
    logic                  tick;
    logic                  adv;
    logic                  at_term;
    logic [6:0]            seg;

`ifdef SEG7_CTRL_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic          db;
    logic [CW-1:0] cnt;

    // Synchronize the button, accept a new level only after DEB_CYCLES stable cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            s3  <= 1'b0;
            db  <= 1'b0;
            cnt <= '0;
        end else if (bus.ena) begin
            s1 <= bus.step_i;
            s2 <= s1;
            s3 <= db;
            if (s2 != db) begin
                if (cnt == CW'(DEB_CYCLES - 1)) begin
                    db  <= s2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign step_p = db & ~s3;
`else
    // Two-flop synchronizer plus a delay flop for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else if (bus.ena) begin
            s1 <= bus.step_i;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign step_p = s2 & ~s3;
`endif

    assign tick    = (state == RUN) && (pc == bus.prescale);
    assign adv     = (state == RUN) ? tick : step_p;
    assign at_term = digit >= bus.term_val;

    // RUN/HOLD FSM with prescaler, digit counter and registered wrap/dp outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HOLD;
            pc    <= '0;
            digit <= 4'd0;
            wrap  <= 1'b0;
            dp    <= 1'b0;
        end else if (!bus.ena) begin
            wrap <= 1'b0;
        end else begin
            state <= bus.run_i ? RUN : HOLD;
            dp    <= bus.run_i;
            pc    <= (state == HOLD || bus.load_i || tick) ? '0 : pc + 1'b1;
            if (bus.load_i) begin
                digit <= bus.load_val;
                wrap  <= 1'b0;
            end else if (adv) begin
                digit <= at_term ? 4'd0 : digit + 4'd1;
                wrap  <= at_term;
            end else begin
                wrap <= 1'b0;
            end
        end
    end

    seg7_decoder u_dec (
        .digit (digit),
        .seg   (seg)
    );

    assign bus.digit_o = digit;
    assign bus.seg_o   = seg;
    assign bus.dp_o    = dp;
    assign bus.wrap_o  = wrap;

endmodule
